// File: rtl/seq_pkg.sv
// Shared types and constants for the sequential-design library.
// The serial blocks pull their FSM state encoding and default word length from here.
package seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with enable and zero flag.
// A load takes priority over a decrement in the same cycle.
module down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on load/ready and shifts it out MSB first,
// one bit per shift_en_in edge, with back-to-back reload on the final bit.
module piso_shift_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_in,
    input  logic             shift_en_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             frame_out,
    output logic             done_out
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             last_bit;
    logic             shift_step;
    logic             accept;

    assign last_bit   = (state == SHIFT) && cnt_zero && shift_en_in;
    assign shift_step = (state == SHIFT) && shift_en_in && !cnt_zero;
    assign accept     = load_in && ready_out;

    down_counter #(.W(CW)) u_cnt (
        .clk      (clk_in),
        .rst      (rst_in),
        .load     (accept),
        .load_val (CNT_INIT),
        .en       (shift_step),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_in) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !load_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_out = 1'b0;
        frame_out = 1'b0;
        ser_out   = 1'b0;
        done_out  = 1'b0;
        case (state)
            IDLE: ready_out = 1'b1;
            SHIFT: begin
                frame_out = 1'b1;
                ser_out   = shreg[WIDTH-1];
                ready_out = last_bit;
                done_out  = last_bit;
            end
            default: ;
        endcase
    end

    // A final-bit reload and a fresh IDLE accept share the same capture path.
    always_ff @(posedge clk_in) begin
        if (rst_in)          shreg <= '0;
        else if (accept)     shreg <= data_in;
        else if (shift_step) shreg <= {shreg[WIDTH-2:0], 1'b0};
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: table-driven words plus hand sequences,
// with a per-cycle expectation queue filled at each accepted word.
module tb_piso_shift_tx;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] data_in = '0;
    logic       load_in = 1'b0;
    logic       shift_en_in = 1'b0;
    logic       ready_out, ser_out, frame_out, done_out;

    piso_shift_tx #(.WIDTH(8)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .data_in     (data_in),
        .load_in     (load_in),
        .shift_en_in (shift_en_in),
        .ready_out   (ready_out),
        .ser_out     (ser_out),
        .frame_out   (frame_out),
        .done_out    (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic en;
        logic frame;
        logic ser;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        int          period;
        logic [15:0] exp_bits;
        int          exp_len;
    } vec_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          period_cur = 1;
    logic [15:0] cap;
    int          fcnt;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkv(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input int p);
        for (int b = 7; b >= 0; b--)
            for (int k = 0; k < p; k++)
                sbq.push_back({(k == p - 1), 1'b1, d[b], (b == 0) && (k == p - 1)});
    endtask

    // One clock: drive, compare at negedge, retire/accept, advance past posedge.
    task automatic run_cycle(input logic ld, input logic [7:0] d, input logic idle_en,
                             output logic acc);
        exp_t e;
        logic exp_rdy;
        e = '0;
        if (sbq.size() > 0) e = sbq[0];
        load_in     = ld;
        data_in     = d;
        shift_en_in = (sbq.size() > 0) ? e.en : idle_en;
        exp_rdy     = (sbq.size() == 0) || e.done;
        @(negedge clk_in);
        check("ready", ready_out, exp_rdy);
        check("frame", frame_out, e.frame);
        check("ser", ser_out, e.ser);
        check("done", done_out, e.done);
        if (frame_out && shift_en_in) cap = {cap[14:0], ser_out};
        if (frame_out) fcnt++;
        acc = ld && exp_rdy;
        if (sbq.size() > 0) void'(sbq.pop_front());
        if (acc) push_word(d, period_cur);
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 200 && sbq.size() > 0; i++)
            run_cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), acc);
        if (sbq.size() != 0) checkv("drain_timeout", sbq.size(), 0);
    endtask

    task automatic send_word(input logic [7:0] d, input int p);
        logic acc;
        int   n;
        period_cur = p;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            run_cycle(1'b1, d, 1'b1, acc);
            n++;
        end
        if (!acc) checkv("accept_timeout", n, 0);
        drain();
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b1; load_in = 1'b1; shift_en_in = 1'b1; data_in = 8'hFF;
        repeat (n) @(posedge clk_in);
        #1;
        rst_in = 1'b0; load_in = 1'b0;
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic acc, acc2;
        int   n;

        vecs[0] = '{8'hA5, 1, 16'h00A5, 8};
        vecs[1] = '{8'h81, 3, 16'h0081, 24};
        vecs[2] = '{8'h5A, 2, 16'h005A, 16};
        vecs[3] = '{8'h01, 1, 16'h0001, 8};

        // Reset with load and enable asserted: must come out idle.
        do_reset(2);
        run_cycle(1'b0, 8'h00, 1'b1, acc);
        run_cycle(1'b0, 8'h00, 1'b0, acc);

        foreach (vecs[i]) begin
            cap = '0; fcnt = 0;
            send_word(vecs[i].data, vecs[i].period);
            checkv("vec_bits", int'(cap), int'(vecs[i].exp_bits));
            checkv("vec_frame_len", fcnt, vecs[i].exp_len);
            run_cycle(1'b0, 8'h00, 1'b1, acc);
        end

        // Back-to-back: hold load with F0 then 0F; no gap between words.
        cap = '0; fcnt = 0; period_cur = 1;
        run_cycle(1'b1, 8'hF0, 1'b1, acc);
        checkv("b2b_first_accept", int'(acc), 1);
        acc2 = 1'b0; n = 0;
        while (!acc2 && n < 20) begin
            run_cycle(1'b1, 8'h0F, 1'b1, acc2);
            n++;
        end
        checkv("b2b_second_accept_cycle", n, 8);
        drain();
        checkv("b2b_bits", int'(cap), 16'hF00F);
        checkv("b2b_frame_len", fcnt, 16);

        // Ignored load during the third bit of FF.
        cap = '0; fcnt = 0; period_cur = 1;
        run_cycle(1'b1, 8'hFF, 1'b1, acc);
        run_cycle(1'b0, 8'h00, 1'b1, acc);
        run_cycle(1'b0, 8'h00, 1'b1, acc);
        run_cycle(1'b1, 8'h00, 1'b1, acc);
        checkv("ignored_load_acc", int'(acc), 0);
        drain();
        checkv("ignored_bits", int'(cap), 16'h00FF);
        run_cycle(1'b0, 8'h00, 1'b1, acc);

        // Mid-frame reset after 4 bits of C3, then 3C sends cleanly.
        period_cur = 1;
        run_cycle(1'b1, 8'hC3, 1'b1, acc);
        repeat (4) run_cycle(1'b0, 8'h00, 1'b1, acc);
        do_reset(1);
        shift_en_in = 1'b1;
        @(negedge clk_in);
        check("rst_mid_ready", ready_out, 1'b1);
        check("rst_mid_frame", frame_out, 1'b0);
        check("rst_mid_ser", ser_out, 1'b0);
        check("rst_mid_done", done_out, 1'b0);
        @(posedge clk_in); #1;
        cap = '0; fcnt = 0;
        send_word(8'h3C, 1);
        checkv("post_rst_bits", int'(cap), 16'h003C);
        checkv("post_rst_frame_len", fcnt, 8);
        run_cycle(1'b0, 8'h00, 1'b1, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
